// File: rtl/multiplier_pp_param.sv
// multiplier_pp_param: pipelined partial-product multiplier, one multiplier slice per stage
module multiplier_pp_param #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iEn,
  input  logic               iClr,
  input  logic               iValid,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iData0,
  input  logic [WIDTH-1:0]   iData1,
  output logic [2*WIDTH-1:0] oData,
  output logic               oValid,
  output logic               oBusy
);
  localparam int SL = WIDTH / STAGES;
  localparam int PW = 2 * WIDTH;
  if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_chk
    $fatal(1, "multiplier_pp_param: illegal WIDTH/STAGES combination");
  end
  logic [STAGES-1:0] v_q, v_d, iv;
  logic              n_q [STAGES];
  logic              n_d [STAGES];
  logic              in_n [STAGES];
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  ia [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  ib [STAGES];
  logic [PW-1:0]     p_q [STAGES];
  logic [PW-1:0]     p_d [STAGES];
  logic [PW-1:0]     ip [STAGES];
  logic [PW-1:0]     s [STAGES];
  // the last stage doubles as the output register, so it holds its product across bubbles
  always_comb begin
    iv[0] = iValid;
    in_n[0] = iSigned & (iData0[WIDTH-1] ^ iData1[WIDTH-1]);
    ia[0] = (iSigned && iData0[WIDTH-1]) ? -iData0 : iData0;
    ib[0] = (iSigned && iData1[WIDTH-1]) ? -iData1 : iData1;
    ip[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      iv[k] = v_q[k-1];
      in_n[k] = n_q[k-1];
      ia[k] = a_q[k-1];
      ib[k] = b_q[k-1];
      ip[k] = p_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      s[k] = ip[k] + ((PW'(ia[k]) * PW'(ib[k][SL-1:0])) << (k * SL));
      v_d[k] = iv[k];
      n_d[k] = in_n[k];
      a_d[k] = ia[k];
      b_d[k] = ib[k] >> SL;
      p_d[k] = s[k];
    end
    p_d[STAGES-1] = iv[STAGES-1] ? (in_n[STAGES-1] ? -s[STAGES-1] : s[STAGES-1]) : p_q[STAGES-1];
  end
  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      v_q <= '0;
      n_q <= '{default: 1'b0};
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      p_q <= '{default: '0};
    end else if (iEn) begin
      v_q <= v_d;
      n_q <= n_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end
  assign oData = p_q[STAGES-1];
  assign oValid = v_q[STAGES-1];
  assign oBusy = |v_q;
endmodule

// File: tb/tb_multiplier_pp_param.sv
// tb_multiplier_pp_param: three depths driven in parallel against an enabled-edge history model
module tb_multiplier_pp_param;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, clr = 1'b0, vld = 1'b0, sgn = 1'b0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [63:0] od1, od4, od8;
  logic ov1, ov4, ov8, ob1, ob4, ob8;
  int nvec = 0, errs = 0, n = 0, base = 0;
  logic hv [4096];
  logic [63:0] hp [4096];
  logic [63:0] r033 [4];

  always #5 clk = ~clk;

  multiplier_pp_param #(.WIDTH(32), .STAGES(1)) u1 (.iClk(clk), .iRst(rst), .iEn(en), .iClr(clr),
    .iValid(vld), .iSigned(sgn), .iData0(d0), .iData1(d1), .oData(od1), .oValid(ov1), .oBusy(ob1));
  multiplier_pp_param #(.WIDTH(32), .STAGES(4)) u4 (.iClk(clk), .iRst(rst), .iEn(en), .iClr(clr),
    .iValid(vld), .iSigned(sgn), .iData0(d0), .iData1(d1), .oData(od4), .oValid(ov4), .oBusy(ob4));
  multiplier_pp_param #(.WIDTH(32), .STAGES(8)) u8 (.iClk(clk), .iRst(rst), .iEn(en), .iClr(clr),
    .iValid(vld), .iSigned(sgn), .iData0(d0), .iData1(d1), .oData(od8), .oValid(ov8), .oBusy(ob8));

  function automatic logic [63:0] prod(logic s, logic [31:0] a, logic [31:0] b);
    logic [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'b0, a};
    y = s ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // after enabled edge n the output shows the entry of edge n-S+1; entries at or before base were flushed
  task automatic chk_dut(string tag, int S, logic v, logic [63:0] d, logic b);
    int o = n - S + 1;
    logic ev = (o > base) && hv[o];
    logic [63:0] ed = '0;
    logic eb = 1'b0;
    for (int i = o; i > base; i--)
      if (hv[i]) begin
        ed = hp[i];
        break;
      end
    for (int i = (o > base ? o : base + 1); i <= n; i++) eb |= hv[i];
    chk({tag, "_valid"}, 64'(v), 64'(ev));
    chk({tag, "_data"}, d, ed);
    chk({tag, "_busy"}, 64'(b), 64'(eb));
  endtask

  task automatic step(logic e, logic c, logic r, logic v, logic s, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    en = e; clr = c; rst = r; vld = v; sgn = s; d0 = a; d1 = b;
    @(posedge clk);
    if (r || c) base = n;
    else if (e) begin
      n++;
      hv[n] = v;
      hp[n] = prod(s, a, b);
    end
    #1;
    chk_dut("s1", 1, ov1, od1, ob1);
    chk_dut("s4", 4, ov4, od4, ob4);
    chk_dut("s8", 8, ov8, od8, ob8);
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r033[0] = 64'h0000000000000001;
    r033[1] = 64'h4000000000000000;
    r033[2] = 64'hFFFFFFFF80000000;
    r033[3] = 64'h0;
    step(1, 0, 1, 1, 0, 32'h5, 32'h5);
    step(0, 1, 1, 1, 0, 32'h5, 32'h5);
    chk("reset_data", od4, 64'h0);
    step(1, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(3);
    chk("max_u_data", od4, 64'hFFFFFFFE00000001);
    chk("max_u_valid", 64'(ov4), 64'h1);
    idle(1);
    chk("max_u_drop", 64'(ov4), 64'h0);
    step(1, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step(1, 0, 0, 1, 1, 32'h80000000, 32'h80000000);
    step(1, 0, 0, 1, 1, 32'h80000000, 32'h00000001);
    step(1, 0, 0, 1, 1, 32'h00000000, 32'hFFFFFFFF);
    chk("signed0", od4, r033[0]);
    for (int i = 1; i < 4; i++) begin
      idle(1);
      chk("signed_b2b", od4, r033[i]);
      chk("signed_b2b_v", 64'(ov4), 64'h1);
    end
    step(1, 0, 0, 1, 0, 32'd3, 32'd5);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, $urandom, $urandom);
    idle(2);
    chk("stall_data", od4, 64'd15);
    chk("stall_valid", 64'(ov4), 64'h1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 32'd100 + i, 32'd7);
    step(0, 1, 0, 1, 0, 32'd9, 32'd9);
    chk("flush_data", od4, 64'h0);
    chk("flush_busy", 64'(ob4), 64'h0);
    idle(5);
    step(1, 0, 0, 1, 0, 32'd11, 32'd13);
    step(1, 0, 0, 1, 1, 32'hFFFFFFF0, 32'd3);
    step(1, 0, 1, 1, 0, 32'd5, 32'd5);
    chk("rst_data", od4, 64'h0);
    step(1, 0, 0, 1, 0, 32'd7, 32'd6);
    idle(3);
    chk("post_rst", od4, 64'd42);
    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0,
           1'($urandom), 1'($urandom), pick(), pick());
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/multiplier_pp_param.md
MULTIPLIER_PP_PARAM -- requirements
Module: multiplier_pp_param

Interface
- REQ-001: Parameter WIDTH, default 32, is the operand width in bits; legal range 2..64.
- REQ-002: Parameter STAGES, default 4, is the pipeline depth in cycles; legal range 1..WIDTH, and WIDTH % STAGES == 0 (elaboration-time check, fatal on violation).
- REQ-003: iClk  input  1  single clock; all state updates on its rising edge.
- REQ-004: iRst  input  1  synchronous, active-high reset.
- REQ-005: iEn  input  1  global advance enable; 0 freezes the whole pipeline.
- REQ-006: iClr  input  1  synchronous flush of all in-flight operations.
- REQ-007: iValid  input  1  iData0/iData1/iSigned carry an operation this cycle.
- REQ-008: iSigned  input  1  1 = two's-complement operands, 0 = unsigned; sampled with iValid.
- REQ-009: iData0  input  WIDTH  multiplicand.
- REQ-010: iData1  input  WIDTH  multiplier.
- REQ-011: oData  output  2*WIDTH  registered product.
- REQ-012: oValid  output  1  oData holds a completed product.
- REQ-013: oBusy  output  1  at least one valid operation is in stages 0..STAGES-1, including the output stage.

Function
- REQ-014: Priority per edge: iRst > iClr > iEn; iClr acts regardless of iEn.
- REQ-015: An operation accepted on an edge with iEn=1 and iValid=1 produces oValid=1 with its product after exactly STAGES enabled edges; latency is counted only on edges with iEn=1.
- REQ-016: Throughput is one operation per enabled cycle; back-to-back operations complete in order with no bubbles inserted.
- REQ-017: An edge with iEn=1 and iValid=0 inserts a bubble; it shall emerge STAGES enabled edges later as oValid=0, with oData holding its last value.
- REQ-018: With iEn=0, every stage register, oData, oValid and oBusy hold their values, and inputs are ignored.
- REQ-019: The datapath is a partial-product accumulator: stage k (0..STAGES-1) adds |iData0| x slice k of |iData1|, shifted by k*WIDTH/STAGES, where a slice is WIDTH/STAGES bits, LSB slice first.
- REQ-020: Each stage carries its own valid bit, sign flag and remaining operand bits.
- REQ-021: Signed mode takes operand magnitudes at stage 0; the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as a WIDTH-bit unsigned value.
- REQ-022: In signed mode the final stage negates the 2*WIDTH-bit sum when the operand signs differ; a zero product is never negative.
- REQ-023: oData is exact modulo 2^(2*WIDTH): unsigned product in unsigned mode, two's-complement product in signed mode; no saturation and no overflow flag.
- REQ-024: Mixed signed and unsigned operations may be interleaved cycle by cycle; each uses its own sampled iSigned.
- REQ-025: STAGES=1 degenerates to one registered full multiply with 1-cycle latency.
- REQ-026: iClr zeroes all valid bits, oValid and oData at the edge; oBusy=0 the following cycle.
- REQ-027: An operation presented on the same edge as iClr is discarded.
- REQ-028: oBusy is the OR of all stage valid bits and oValid.

Reset
- REQ-029: On an iRst=1 edge: all stage registers 0, oData=0, oValid=0, oBusy=0; iEn, iClr and iValid are ignored.
- REQ-030: Reset asserted mid-operation discards all in-flight operations; no result from before reset ever appears.
- REQ-031: The first operation accepted on the edge after iRst deasserts completes with normal STAGES latency.

Verification
- REQ-032: WIDTH=32, STAGES=4, unsigned: 0xFFFFFFFF x 0xFFFFFFFF -> oData=0xFFFFFFFE00000001 with oValid=1 exactly 4 edges later and oValid=0 on the next edge.
- REQ-033: Signed, back-to-back operations:
  - -1 x -1 -> 0x0000000000000001;
  - 0x80000000 x 0x80000000 -> 0x4000000000000000;
  - 0x80000000 x 0x00000001 -> 0xFFFFFFFF80000000;
  - 0x00000000 x 0xFFFFFFFF -> 0;
  - expected results on 4 consecutive oValid cycles.
- REQ-034: Stall test: accept 3 x 5; drop iEn for 3 cycles after the second edge; result 15 appears 7 edges after acceptance; oData/oValid are constant during the stall.
- REQ-035: Flush test: iClr pulsed with 3 operations in flight -> oValid=0 and oData=0 next cycle; oBusy=0; none of the 3 results ever appear.
- REQ-036: Random test: 1000 random operands with random iSigned, iValid and iEn (iEn=1 with probability 80%) against a delayed behavioural model, on every enabled edge; also repeated with STAGES=1 and STAGES=8.
- REQ-037: Reset test: iRst asserted for 1 cycle mid-stream -> all outputs 0 next cycle; the post-reset operation 7 x 6 -> 42 after 4 edges.
